// File: rtl/modular_multiplier_seq_if.sv
// Handshake/operand bundle for modular_multiplier_seq.
//   master : requester side (drives start and operands, observes results)
//   slave  : multiplier side
// Signals: start, a, b, modulo (request); busy, done, product, error (result).
// Optional: is_one is present only when MODMUL_IS_ONE_EN is defined.
interface modular_multiplier_seq_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] modulo;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] product;
    logic             error;
`ifdef MODMUL_IS_ONE_EN
    logic             is_one;
`endif

    modport master (
        output start, a, b, modulo,
        input  busy, done, product, error
`ifdef MODMUL_IS_ONE_EN
        , input is_one
`endif
    );

    modport slave (
        input  start, a, b, modulo,
        output busy, done, product, error
`ifdef MODMUL_IS_ONE_EN
        , output is_one
`endif
    );
endinterface

// File: rtl/modular_multiplier_seq.sv
// Sequential modular multiplier: product = (a * b) mod modulo.
// MSB-first interleaved double-and-add, one bit of b per cycle, with a
// conditional subtract after each double and each add so the accumulator
// stays below the modulus. No divider and no full-width product.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous, active-high reset
//   bus  - modular_multiplier_seq_if.slave (start/a/b/modulo in,
//          busy/done/product/error out, is_one when enabled)
//
// Optional feature macro: MODMUL_IS_ONE_EN adds the registered is_one flag
// (product == 1 with no error), a single-bit inverse-verification result.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for start; operands latched when it is accepted
// S_CALC | one double-and-add step per cycle, bit index WIDTH-1 down to 0
// S_DONE | done pulse for one cycle, result registers valid
module modular_multiplier_seq #(
    parameter int WIDTH = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    modular_multiplier_seq_if.slave   bus
);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH:0]     acc_q, acc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   product_q, product_d;
    logic               error_q, error_d;
    logic               is_one_q, is_one_d;

    // Datapath for one step; WIDTH+1 bits so 2*acc and t+a never overflow
    // even at modulo = 2^WIDTH-1.
    logic [WIDTH:0]     m_ext;
    logic [WIDTH:0]     t_dbl;
    logic [WIDTH:0]     t_red;
    logic [WIDTH:0]     t_add;
    logic [WIDTH:0]     t_next;

    always_comb begin
        m_ext  = {1'b0, m_q};
        t_dbl  = {acc_q[WIDTH-1:0], 1'b0};
        t_red  = (t_dbl >= m_ext) ? (t_dbl - m_ext) : t_dbl;
        t_add  = b_q[idx_q] ? (t_red + {1'b0, a_q}) : t_red;
        t_next = (t_add >= m_ext) ? (t_add - m_ext) : t_add;
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        m_d       = m_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        product_d = product_q;
        error_d   = error_q;
        is_one_d  = is_one_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d = bus.a;
                    b_d = bus.b;
                    m_d = bus.modulo;
                    if ((bus.modulo == '0) || (bus.a >= bus.modulo)) begin
                        product_d = '0;
                        error_d   = 1'b1;
                        is_one_d  = 1'b0;
                        state_d   = S_DONE;
                    end else begin
                        // product/error keep their old values until the run ends
                        acc_d   = '0;
                        idx_d   = IDX_W'(WIDTH - 1);
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                acc_d = t_next;
                if (idx_q == '0) begin
                    product_d = t_next[WIDTH-1:0];
                    error_d   = 1'b0;
                    is_one_d  = (t_next == (WIDTH+1)'(1));
                    state_d   = S_DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            m_q       <= '0;
            acc_q     <= '0;
            idx_q     <= '0;
            product_q <= '0;
            error_q   <= 1'b0;
            is_one_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            m_q       <= m_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            product_q <= product_d;
            error_q   <= error_d;
            is_one_q  <= is_one_d;
        end
    end

    assign bus.busy    = (state_q == S_CALC) || (state_q == S_DONE);
    assign bus.done    = (state_q == S_DONE);
    assign bus.product = product_q;
    assign bus.error   = error_q;
`ifdef MODMUL_IS_ONE_EN
    assign bus.is_one  = is_one_q;
`else
    // Without the flag output the register has no reader.
    logic unused_is_one;
    assign unused_is_one = is_one_q;
`endif

endmodule
